// File: rtl/boot_loader.sv
// Stream boot loader: parses target/address/count/data/checksum records into
// ROM/RAM write strobes and holds the CPU in reset until the load completes.
module boot_loader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              rom_we,
  output logic              ram_we,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  bytes_loaded
);

  localparam int unsigned HI_W = ADDR_W - 8;
  localparam int unsigned CH_W = CNT_W - 8;

  typedef enum logic [3:0] {
    S_TGT, S_AH, S_AL, S_CH, S_CL, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [1:0]         w_err_code;
  logic [CNT_W-1:0]   w_cnt_full;
  logic               r_is_ram;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_csum;

  assign w_accept   = in_valid && in_ready;
  assign w_cnt_full = {r_cnt[CNT_W-1:8], in_data[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_TGT;
    else     r_state <= w_next;
  end

  // Record parser: advances once per accepted byte
  always_comb begin
    w_next     = r_state;
    w_err_code = 2'b00;
    if (w_accept) begin
      case (r_state)
        S_TGT: begin
          if (in_data == '1) begin
            w_next = S_DONE;
          end else if (in_data[DATA_W-1:1] == '0) begin
            w_next = S_AH;
          end else begin
            w_next     = S_ERR;
            w_err_code = 2'b01;
          end
        end
        S_AH:   w_next = S_AL;
        S_AL:   w_next = S_CH;
        S_CH:   w_next = S_CL;
        S_CL:   w_next = (w_cnt_full == '0) ? S_CSUM : S_DATA;
        S_DATA: w_next = (r_cnt == CNT_W'(1)) ? S_CSUM : S_DATA;
        S_CSUM: begin
          if (in_data == r_csum) begin
            w_next = S_TGT;
          end else begin
            w_next     = S_ERR;
            w_err_code = 2'b10;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      rom_we       <= 1'b0;
      ram_we       <= 1'b0;
      cpu_rst_n    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      bytes_loaded <= '0;
      r_is_ram     <= 1'b0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_csum       <= '0;
    end else begin
      rom_we    <= 1'b0;
      ram_we    <= 1'b0;
      in_ready  <= (w_next != S_DONE) && (w_next != S_ERR);
      done      <= (w_next == S_DONE);
      cpu_rst_n <= (w_next == S_DONE);
      err       <= (w_next == S_ERR);
      if ((w_next == S_ERR) && (r_state != S_ERR)) err_code <= w_err_code;
      if (w_accept) begin
        case (r_state)
          S_TGT: r_is_ram <= in_data[0];
          S_AH:  r_addr[ADDR_W-1:8] <= in_data[HI_W-1:0];
          S_AL:  r_addr[7:0] <= in_data[7:0];
          S_CH:  r_cnt[CNT_W-1:8] <= CH_W'(in_data);
          S_CL: begin
            r_cnt  <= w_cnt_full;
            r_csum <= '0;
          end
          S_DATA: begin
            // Strobe lands in the cycle right after the byte is accepted
            mem_addr <= r_addr;
            mem_data <= in_data;
            rom_we   <= ~r_is_ram;
            ram_we   <= r_is_ram;
            r_addr   <= r_addr + ADDR_W'(1);
            r_cnt    <= r_cnt - CNT_W'(1);
            r_csum   <= r_csum ^ in_data;
            if (bytes_loaded != '1) bytes_loaded <= bytes_loaded + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed record table, reset/async sequences and
// randomized record streams checked against a record-level parser model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        rom_we, ram_we, cpu_rst_n, done, err;
  logic [1:0]  err_code;
  logic [15:0] bytes_loaded;

  boot_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rom_we(rom_we), .ram_we(ram_we), .cpu_rst_n(cpu_rst_n), .done(done),
    .err(err), .err_code(err_code), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ram;
    logic [12:0] addr;
    logic [7:0]  data;
    int          tag;   // expected: stream index of the data byte; observed: cycle
  } wr_t;

  typedef struct {
    logic [159:0] s;    // stream bytes, right-justified, first byte leftmost
    int           len;
    logic [127:0] w;    // writes as {8'h0R, 16'hADDR, 8'hDD}, right-justified
    int           nw;
    bit           done;
    bit           err;
    logic [1:0]   code;
    logic [15:0]  nb;
  } vec_t;

  int          n_vec = 0, n_miss = 0;
  int          cyc = 0;
  string       cur_tag = "init";
  wr_t         exp_q[$], obs_q[$];
  int          acc_q[$];
  logic [7:0]  stim[$];
  bit          e_done, e_err;
  logic [1:0]  e_code;
  logic [15:0] e_nb;
  int          e_used;
  vec_t        tv[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s got=%h want=%h (t=%0t)", cur_tag, nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe seen in a cycle
  always @(negedge clk) begin
    if (!rst && (rom_we || ram_we)) begin
      wr_t o;
      chk("we_exclusive", 32'(rom_we & ram_we), 32'd0);
      o.ram = ram_we; o.addr = mem_addr; o.data = mem_data; o.tag = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ctl"}, 32'({in_ready, rom_we, ram_we, cpu_rst_n, done, err, err_code}), 32'd0);
    chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_data"}, 32'(mem_data), 32'd0);
    chk({nm, "_bytes"}, 32'(bytes_loaded), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete(); acc_q.delete();
  endtask

  // Called at a negedge; returns at the negedge following acceptance
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0; ok = 1'b0;
      return;
    end
    @(negedge clk);
    acc_q.push_back(cyc);
    in_valid = 1'b0; ok = 1'b1;
  endtask

  // Record-level reference: walks the byte stream as records
  function automatic void model();
    int p = 0, cnt;
    logic [7:0] t, ah, al, x, d;
    logic [12:0] a;
    wr_t e;
    exp_q.delete(); e_done = 0; e_err = 0; e_code = 2'b00; e_nb = 16'd0;
    while (p < stim.size()) begin
      t = stim[p]; p++;
      if (t == 8'hFF) begin e_done = 1; break; end
      if (t > 8'h01) begin e_err = 1; e_code = 2'b01; break; end
      ah = stim[p]; al = stim[p+1];
      a = {ah[4:0], al};
      cnt = 256 * int'(stim[p+2]) + int'(stim[p+3]);
      p += 4;
      x = 8'h00;
      for (int i = 0; i < cnt; i++) begin
        d = stim[p];
        e.ram = t[0]; e.addr = a; e.data = d; e.tag = p;
        exp_q.push_back(e);
        x = x ^ d;
        a = 13'((int'(a) + 1) % 8192);
        if (e_nb != 16'hFFFF) e_nb++;
        p++;
      end
      d = stim[p]; p++;
      if (d != x) begin e_err = 1; e_code = 2'b10; break; end
    end
    e_used = p;
  endfunction

  task automatic gen_random();
    int nrec, cnt;
    logic [7:0] x, d;
    logic [15:0] a;
    stim.delete();
    nrec = $urandom_range(1, 4);
    for (int r = 0; r < nrec; r++) begin
      if ($urandom_range(0, 15) == 0) begin
        stim.push_back(8'($urandom_range(2, 254)));
        break;
      end
      stim.push_back(8'($urandom_range(0, 1)));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
      stim.push_back(a[15:8]); stim.push_back(a[7:0]);
      cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      stim.push_back(8'h00); stim.push_back(8'(cnt));
      x = 8'h00;
      for (int i = 0; i < cnt; i++) begin
        d = 8'($urandom); stim.push_back(d); x = x ^ d;
      end
      if ($urandom_range(0, 7) == 0) x = x ^ 8'($urandom_range(1, 255));
      stim.push_back(x);
    end
    stim.push_back(8'hFF);
  endtask

  task automatic run_and_check(input bit timed);
    bit ok = 1'b1;
    int n;
    for (int i = 0; i < e_used && ok; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_byte(stim[i], ok);
    end
    in_valid = 1'b1;
    repeat (3) begin in_data = 8'($urandom); @(negedge clk); end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("err_code", 32'(err_code), 32'(e_code));
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(e_done));
    chk("in_ready", 32'(in_ready), 32'(!(e_done || e_err)));
    chk("bytes_loaded", 32'(bytes_loaded), 32'(e_nb));
    chk("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk("write", 32'({obs_q[k].ram, obs_q[k].addr, obs_q[k].data}),
                   32'({exp_q[k].ram, exp_q[k].addr, exp_q[k].data}));
      if (timed && exp_q[k].tag < acc_q.size())
        chk("strobe_cycle", 32'(obs_q[k].tag), 32'(acc_q[exp_q[k].tag]));
    end
  endtask

  task automatic load_vec(input int idx);
    logic [31:0] ww;
    wr_t e;
    stim.delete(); exp_q.delete();
    for (int i = 0; i < tv[idx].len; i++) stim.push_back(tv[idx].s[(tv[idx].len-1-i)*8 +: 8]);
    for (int k = 0; k < tv[idx].nw; k++) begin
      ww = tv[idx].w[(tv[idx].nw-1-k)*32 +: 32];
      e.ram = ww[24]; e.addr = ww[20:8]; e.data = ww[7:0]; e.tag = -1;
      exp_q.push_back(e);
    end
    e_done = tv[idx].done; e_err = tv[idx].err; e_code = tv[idx].code;
    e_nb = tv[idx].nb; e_used = tv[idx].len;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tv[0] = '{160'h00_00_00_00_03_AA_55_0F_F0_FF, 10,
              128'h00_0000_AA_00_0001_55_00_0002_0F, 3, 1'b1, 1'b0, 2'b00, 16'd3};
    tv[1] = '{160'h00_00_10_00_01_12_12_01_18_02_00_02_34_56_62_FF, 16,
              128'h00_0010_12_01_1802_34_01_1803_56, 3, 1'b1, 1'b0, 2'b00, 16'd3};
    tv[2] = '{160'h01_00_00_00_02_01_02_00, 8,
              128'h01_0000_01_01_0001_02, 2, 1'b0, 1'b1, 2'b10, 16'd2};
    tv[3] = '{160'h07, 1, 128'h0, 0, 1'b0, 1'b1, 2'b01, 16'd0};
    tv[4] = '{160'h00_1F_FF_00_02_11_22_33_00_00_05_00_00_00_FF, 15,
              128'h00_1FFF_11_00_0000_22, 2, 1'b1, 1'b0, 2'b00, 16'd2};
    tv[5] = '{160'h01_E3_45_00_01_99_99_FF, 8,
              128'h01_0345_99, 1, 1'b1, 1'b0, 2'b00, 16'd1};

    for (int v = 0; v < 6; v++) begin
      cur_tag = $sformatf("vec%0d", v);
      do_reset();
      load_vec(v);
      run_and_check(1'b0);
    end

    // Asynchronous reset while a data strobe is in flight
    cur_tag = "midload_rst";
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'hAA};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) repeat (2) @(negedge clk);
      send_byte(stim[i], ok);
    end
    chk("strobe_before_rst", 32'({rom_we, mem_data}), 32'({1'b1, 8'hAA}));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete(); acc_q.delete();
    cur_tag = "reload";
    load_vec(0);
    run_and_check(1'b0);

    for (int r = 0; r < 40; r++) begin
      cur_tag = $sformatf("rand%0d", r);
      do_reset();
      gen_random();
      model();
      run_and_check(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
